udp_tx_packetizer: RTL and testbench
====================================

Name: udp_tx_packetizer

Overview:
Collects a raw byte stream from the tape datapath into UDP datagrams. Drives the UDP frame input (header plus payload AXI-stream) of the UDP/IP stack on the transmit side. Each datagram closes on one of three events: the payload reaches MAX_PAYLOAD bytes, an explicit end marker arrives, or an idle timeout expires. It then issues one header handshake followed by the buffered payload.

Parameters:
MAX_PAYLOAD, 1024, bytes per datagram before a forced flush; legal range 1..1472.
TIMEOUT_CYCLES, 125000, idle clk cycles with a partially filled buffer before a flush (1 ms at 125 MHz); must be >= 2.
SRC_PORT, 16'd5000, UDP source port.
DEST_PORT, 16'd5000, UDP destination port.
IP_TTL, 8'd64, IP TTL placed in the header.

Ports:
clk  in  1  125 MHz system clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  8  input byte
s_axis_tvalid  in  1  input byte valid
s_axis_tready  out  1  input accept
s_axis_tlast  in  1  flush request after this byte
local_ip  in  32  source IP, sampled at flush
remote_ip  in  32  destination IP, sampled at flush
m_udp_hdr_valid  out  1  header valid
m_udp_hdr_ready  in  1  header accept
m_udp_ip_dscp  out  6  constant 0
m_udp_ip_ecn  out  2  constant 0
m_udp_ip_ttl  out  8  IP_TTL
m_udp_ip_source_ip  out  32  latched local_ip
m_udp_ip_dest_ip  out  32  latched remote_ip
m_udp_source_port  out  16  SRC_PORT
m_udp_dest_port  out  16  DEST_PORT
m_udp_length  out  16  payload byte count + 8
m_udp_checksum  out  16  constant 0; the stack generates the checksum
m_udp_payload_axis_tdata  out  8  payload byte
m_udp_payload_axis_tvalid  out  1  payload valid
m_udp_payload_axis_tready  in  1  payload accept
m_udp_payload_axis_tlast  out  1  last payload byte
m_udp_payload_axis_tuser  out  1  constant 0
busy  out  1  high in HDR or SEND

Behaviour:
- Reset state and reset values:
  - state=FILL, count=0, timer=0.
  - s_axis_tready=1.
  - m_udp_hdr_valid=0, m_udp_payload_axis_tvalid=0, m_udp_payload_axis_tlast=0, busy=0.
  - Latched IPs=0, m_udp_length=8.
- A handshake occurs when valid and ready are both high on a rising clk edge.
- FILL state:
  - s_axis_tready=1.
  - Each accepted byte is written to buffer[count]; count then increments and timer clears.
  - While count>0 and no byte is accepted, timer increments.
  - Exit to HDR on the next edge when any of these holds:
    - an accepted byte carries tlast;
    - an accepted byte makes count==MAX_PAYLOAD;
    - timer==TIMEOUT_CYCLES-1 and no byte is accepted.
  - On exit, latch local_ip, remote_ip and m_udp_length=count_final+8.
  - The timeout flush therefore asserts hdr_valid exactly TIMEOUT_CYCLES cycles after the last accepted byte.
- HDR state:
  - s_axis_tready=0 and m_udp_hdr_valid=1.
  - All header outputs stay stable until hdr_ready.
  - On the header handshake, go to SEND with rd_ptr=0.
- SEND state:
  - s_axis_tready=0.
  - Buffer bytes 0..count-1 stream in order.
  - tlast=1 only on byte count-1.
  - The first payload tvalid may assert 1 cycle after the header handshake (registered RAM read).
  - After that, throughput is 1 byte/clk while tready=1, with no bubbles. A prefetch/skid register keeps tdata stable under backpressure.
  - On the tlast handshake, go to FILL with count=0 and timer=0. s_axis_tready=1 from the next cycle.
- Widths and invariants:
  - count and rd_ptr are $clog2(MAX_PAYLOAD+1) bits; timer is $clog2(TIMEOUT_CYCLES) bits.
  - A datagram is never empty. Flushes happen only with count>=1, and the timer never counts at count==0.
  - tlast on the byte that also fills the buffer produces exactly one flush.
- Reset mid-operation:
  - Buffered data and the in-flight datagram are discarded.
  - All outputs take their reset values on the cycle after rst is sampled high.
  - No partial header or payload handshake continues after reset.
- remote_ip/local_ip changes during HDR or SEND do not affect the current datagram.

Decomposition:
- Shared package udp_tx_pkg:
  - state enum {FILL, HDR, SEND};
  - UDP_HDR_LEN=8;
  - UDP_MAX_PAYLOAD_LIMIT=1472.
- Sub-module udp_tx_buffer_ram:
  - simple dual-port RAM, depth MAX_PAYLOAD, 8-bit;
  - write port from FILL, registered read port for SEND.
  - Inferable as Altera block RAM.

Test Plan:
- 4 bytes 0x11,0x12,0x13,0x14 with tlast on 0x14, hdr_ready=1 → one header with length=12, src/dst ports 5000, TTL 64. Payload is 11 12 13 14 with tlast only on 0x14.
- 1024 consecutive bytes (MAX_PAYLOAD=1024), no tlast → one header with length=1032. s_axis_tready is low from the cycle after byte 1024 until the final payload handshake. Payload matches input.
- TIMEOUT_CYCLES=100: 3 bytes then idle → hdr_valid asserts exactly 100 cycles after the 3rd accept, length=11. No header ever appears while count==0.
- hdr_ready held low 50 cycles → hdr_valid and all header fields constant, s_axis_tready=0, remote_ip changes ignored.
- Random payload tready (50%) over 10 datagrams of random sizes 1..1024 → byte-exact order, no loss or duplication, one tlast per datagram, tdata stable while stalled.
- rst pulsed 1 cycle mid-SEND (byte 200 of 500) → next cycle tvalid=0, hdr_valid=0, s_axis_tready=1. The next 5-byte datagram has length=13 and correct data.

Source files
------------

// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit packetizer.
package udp_tx_pkg;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HDR  = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam int UDP_HDR_LEN           = 8;
   localparam int UDP_MAX_PAYLOAD_LIMIT = 1472;

   // Address width that stays legal for a single-entry buffer.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/udp_tx_buffer_ram.sv
// Simple dual-port payload buffer: write port fed while filling, registered read with enable.
module udp_tx_buffer_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // The read register only updates on re, so it doubles as the stall-holding output stage.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/udp_tx_packetizer.sv
// Packs a byte stream into UDP datagrams: flush on tlast, full buffer or idle timeout.
//
// state | meaning
// FILL  | accepting input bytes into the buffer, idle timer running when non-empty
// HDR   | presenting the latched UDP header, waiting for hdr_ready
// SEND  | streaming buffered payload bytes, tlast on the final one
module udp_tx_packetizer
   import udp_tx_pkg::*;
#(
   parameter int          MAX_PAYLOAD    = 1024,
   parameter int          TIMEOUT_CYCLES = 125000,
   parameter logic [15:0] SRC_PORT       = 16'd5000,
   parameter logic [15:0] DEST_PORT      = 16'd5000,
   parameter logic [7:0]  IP_TTL         = 8'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   input  logic [31:0] local_ip,
   input  logic [31:0] remote_ip,
   output logic        m_udp_hdr_valid,
   input  logic        m_udp_hdr_ready,
   output logic [5:0]  m_udp_ip_dscp,
   output logic [1:0]  m_udp_ip_ecn,
   output logic [7:0]  m_udp_ip_ttl,
   output logic [31:0] m_udp_ip_source_ip,
   output logic [31:0] m_udp_ip_dest_ip,
   output logic [15:0] m_udp_source_port,
   output logic [15:0] m_udp_dest_port,
   output logic [15:0] m_udp_length,
   output logic [15:0] m_udp_checksum,
   output logic [7:0]  m_udp_payload_axis_tdata,
   output logic        m_udp_payload_axis_tvalid,
   input  logic        m_udp_payload_axis_tready,
   output logic        m_udp_payload_axis_tlast,
   output logic        m_udp_payload_axis_tuser,
   output logic        busy
);

   localparam int CW = $clog2(MAX_PAYLOAD + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int AW = addr_width(MAX_PAYLOAD);

   localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_PAYLOAD);
   localparam logic [TW-1:0] TIMER_TC  = TW'(TIMEOUT_CYCLES - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] count, count_inc, rd_ptr;
   logic [TW-1:0] timer;
   logic          pay_valid, pay_last;
   logic          fill_fire, flush_data, flush_timeout, hdr_fire, pay_fire;
   logic          ram_re;
   logic [AW-1:0] ram_raddr;
   logic [7:0]    ram_rdata;
   logic [31:0]   src_ip_q, dst_ip_q;
   logic [15:0]   length_q;

   assign count_inc = count + 1'b1;

   always_comb begin
      state_nxt       = state;
      s_axis_tready   = 1'b0;
      m_udp_hdr_valid = 1'b0;
      fill_fire       = 1'b0;
      flush_data      = 1'b0;
      flush_timeout   = 1'b0;
      hdr_fire        = 1'b0;
      pay_fire        = 1'b0;
      case (state)
         FILL: begin
            s_axis_tready = 1'b1;
            fill_fire     = s_axis_tvalid;
            flush_data    = fill_fire && (s_axis_tlast || (count_inc == COUNT_MAX));
            flush_timeout = !fill_fire && (count != '0) && (timer == TIMER_TC);
            if (flush_data || flush_timeout)
               state_nxt = HDR;
         end
         HDR: begin
            m_udp_hdr_valid = 1'b1;
            hdr_fire        = m_udp_hdr_ready;
            if (hdr_fire)
               state_nxt = SEND;
         end
         SEND: begin
            pay_fire = pay_valid && m_udp_payload_axis_tready;
            if (pay_fire && pay_last)
               state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= FILL;
      else
         state <= state_nxt;
   end

   // Next read is issued on the header handshake and on every non-final payload handshake,
   // so the registered RAM output always holds the byte currently presented.
   assign ram_re    = hdr_fire || (pay_fire && !pay_last);
   assign ram_raddr = hdr_fire ? '0 : rd_ptr[AW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         timer     <= '0;
         rd_ptr    <= '0;
         pay_valid <= 1'b0;
         pay_last  <= 1'b0;
         src_ip_q  <= '0;
         dst_ip_q  <= '0;
         length_q  <= 16'(UDP_HDR_LEN);
      end else begin
         if (fill_fire) begin
            count <= count_inc;
            timer <= '0;
         end else if (flush_timeout) begin
            timer <= '0;
         end else if ((state == FILL) && (count != '0)) begin
            timer <= timer + 1'b1;
         end

         if (flush_data || flush_timeout) begin
            src_ip_q <= local_ip;
            dst_ip_q <= remote_ip;
            length_q <= 16'(flush_data ? count_inc : count) + 16'(UDP_HDR_LEN);
         end

         if (hdr_fire) begin
            rd_ptr    <= CW'(1);
            pay_valid <= 1'b1;
            pay_last  <= (count == CW'(1));
         end

         if (pay_fire) begin
            if (pay_last) begin
               pay_valid <= 1'b0;
               pay_last  <= 1'b0;
               count     <= '0;
               timer     <= '0;
               rd_ptr    <= '0;
            end else begin
               rd_ptr   <= rd_ptr + 1'b1;
               pay_last <= (rd_ptr == count - 1'b1);
            end
         end
      end
   end

   udp_tx_buffer_ram #(
      .DEPTH (MAX_PAYLOAD),
      .AW    (AW)
   ) u_buffer_ram (
      .clk   (clk),
      .we    (fill_fire),
      .waddr (count[AW-1:0]),
      .wdata (s_axis_tdata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign m_udp_ip_dscp      = 6'd0;
   assign m_udp_ip_ecn       = 2'd0;
   assign m_udp_ip_ttl       = IP_TTL;
   assign m_udp_ip_source_ip = src_ip_q;
   assign m_udp_ip_dest_ip   = dst_ip_q;
   assign m_udp_source_port  = SRC_PORT;
   assign m_udp_dest_port    = DEST_PORT;
   assign m_udp_length       = length_q;
   assign m_udp_checksum     = 16'd0;

   assign m_udp_payload_axis_tdata  = ram_rdata;
   assign m_udp_payload_axis_tvalid = pay_valid;
   assign m_udp_payload_axis_tlast  = pay_last;
   assign m_udp_payload_axis_tuser  = 1'b0;

   assign busy = (state != FILL);

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Scoreboard bench for udp_tx_packetizer: randomized byte stream against a datagram-level model.
module tb_udp_tx_packetizer;

   localparam int MAX = 1024;
   localparam int TO  = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [31:0] local_ip = 32'hC0A8_0001;
   logic [31:0] remote_ip = 32'hC0A8_0002;
   logic        m_udp_hdr_valid;
   logic        m_udp_hdr_ready = 1'b0;
   logic [5:0]  m_udp_ip_dscp;
   logic [1:0]  m_udp_ip_ecn;
   logic [7:0]  m_udp_ip_ttl;
   logic [31:0] m_udp_ip_source_ip;
   logic [31:0] m_udp_ip_dest_ip;
   logic [15:0] m_udp_source_port;
   logic [15:0] m_udp_dest_port;
   logic [15:0] m_udp_length;
   logic [15:0] m_udp_checksum;
   logic [7:0]  m_udp_payload_axis_tdata;
   logic        m_udp_payload_axis_tvalid;
   logic        m_udp_payload_axis_tready = 1'b0;
   logic        m_udp_payload_axis_tlast;
   logic        m_udp_payload_axis_tuser;
   logic        busy;

   udp_tx_packetizer #(
      .MAX_PAYLOAD    (MAX),
      .TIMEOUT_CYCLES (TO),
      .SRC_PORT       (16'd5000),
      .DEST_PORT      (16'd5000),
      .IP_TTL         (8'd64)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .s_axis_tdata              (s_axis_tdata),
      .s_axis_tvalid             (s_axis_tvalid),
      .s_axis_tready             (s_axis_tready),
      .s_axis_tlast              (s_axis_tlast),
      .local_ip                  (local_ip),
      .remote_ip                 (remote_ip),
      .m_udp_hdr_valid           (m_udp_hdr_valid),
      .m_udp_hdr_ready           (m_udp_hdr_ready),
      .m_udp_ip_dscp             (m_udp_ip_dscp),
      .m_udp_ip_ecn              (m_udp_ip_ecn),
      .m_udp_ip_ttl              (m_udp_ip_ttl),
      .m_udp_ip_source_ip        (m_udp_ip_source_ip),
      .m_udp_ip_dest_ip          (m_udp_ip_dest_ip),
      .m_udp_source_port         (m_udp_source_port),
      .m_udp_dest_port           (m_udp_dest_port),
      .m_udp_length              (m_udp_length),
      .m_udp_checksum            (m_udp_checksum),
      .m_udp_payload_axis_tdata  (m_udp_payload_axis_tdata),
      .m_udp_payload_axis_tvalid (m_udp_payload_axis_tvalid),
      .m_udp_payload_axis_tready (m_udp_payload_axis_tready),
      .m_udp_payload_axis_tlast  (m_udp_payload_axis_tlast),
      .m_udp_payload_axis_tuser  (m_udp_payload_axis_tuser),
      .busy                      (busy)
   );

   always #4 clk = ~clk;

   typedef struct {
      logic [15:0] len;
      logic [31:0] sip;
      logic [31:0] dip;
      int          cyc;
   } hdr_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } pb_t;

   hdr_t       exp_hdr[$];
   pb_t        exp_pay[$];
   logic [7:0] pend[$];
   int         idle = 0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   int         hdr_hold = 0;
   int         hdr_wait = 0;
   int         hdr_pct = 100;
   int         pay_pct = 100;
   bit         pay_force_low = 1'b0;
   int         pay_popped = 0;

   logic        prev_hv = 1'b0;
   logic [15:0] prev_len;
   logic [31:0] prev_sip, prev_dip;
   logic        prev_tv = 1'b0;
   logic [7:0]  prev_td;
   logic        prev_tl;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a datagram closes on tlast, on reaching MAX bytes, or after TO idle
   // cycles with data pending; header fields are captured at that moment.
   function automatic void flush();
      hdr_t h;
      pb_t  p;
      h.len = 16'(pend.size() + 8);
      h.sip = local_ip;
      h.dip = remote_ip;
      h.cyc = cyc + 1;
      exp_hdr.push_back(h);
      foreach (pend[i]) begin
         p.d = pend[i];
         p.l = (i == pend.size() - 1);
         exp_pay.push_back(p);
      end
      pend.delete();
      idle = 0;
   endfunction

   task automatic step(input logic v, input logic [7:0] d, input logic l, output logic fired);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      fired = v && s_axis_tready;
      if (fired) begin
         pend.push_back(d);
         idle = 0;
         if (l || pend.size() == MAX)
            flush();
      end else if (pend.size() > 0) begin
         idle++;
         if (idle == TO)
            flush();
      end
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      logic f;
      for (int i = 0; i < n; i++)
         step(1'b0, 8'h00, 1'b0, f);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      logic f;
      int   n = 0;
      do begin
         step(1'b1, d, l, f);
         n++;
      end while (!f && n < 5000);
      check("input_accept_bound", 32'(f), 32'd1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_hdr.size() != 0 || exp_pay.size() != 0 || pend.size() != 0 || busy) && n < 20000) begin
         idle_cycles(1);
         n++;
      end
      check("drain_bound", 32'(n < 20000), 32'd1);
   endtask

   // Output-side driver and monitor: ready generation, then scoreboard pops and stability checks.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_hv  = 1'b0;
         prev_tv  = 1'b0;
         hdr_wait = 0;
      end else begin
         if (m_udp_hdr_valid && hdr_wait < hdr_hold) begin
            m_udp_hdr_ready = 1'b0;
            hdr_wait++;
         end else begin
            m_udp_hdr_ready = ($urandom_range(99) < hdr_pct);
         end
         if (!m_udp_hdr_valid)
            hdr_wait = 0;
         m_udp_payload_axis_tready = !pay_force_low && ($urandom_range(99) < pay_pct);

         check("tready_vs_busy", 32'(s_axis_tready), 32'(!busy));

         if (m_udp_hdr_valid) begin
            check("hdr_busy", 32'(busy), 32'd1);
            if (prev_hv) begin
               check("hdr_len_stable", 32'(m_udp_length), 32'(prev_len));
               check("hdr_sip_stable", m_udp_ip_source_ip, prev_sip);
               check("hdr_dip_stable", m_udp_ip_dest_ip, prev_dip);
            end else if (exp_hdr.size() > 0) begin
               check("hdr_rise_cycle", 32'(cyc), 32'(exp_hdr[0].cyc));
            end
            if (m_udp_hdr_ready) begin
               check("hdr_expected", 32'(exp_hdr.size() > 0), 32'd1);
               if (exp_hdr.size() > 0) begin
                  hdr_t h;
                  h = exp_hdr.pop_front();
                  check("hdr_length", 32'(m_udp_length), 32'(h.len));
                  check("hdr_src_ip", m_udp_ip_source_ip, h.sip);
                  check("hdr_dst_ip", m_udp_ip_dest_ip, h.dip);
                  check("hdr_src_port", 32'(m_udp_source_port), 32'd5000);
                  check("hdr_dst_port", 32'(m_udp_dest_port), 32'd5000);
                  check("hdr_ttl", 32'(m_udp_ip_ttl), 32'd64);
                  check("hdr_dscp_ecn", 32'({m_udp_ip_dscp, m_udp_ip_ecn}), 32'd0);
                  check("hdr_checksum", 32'(m_udp_checksum), 32'd0);
               end
            end
         end
         prev_hv  = m_udp_hdr_valid && !m_udp_hdr_ready;
         prev_len = m_udp_length;
         prev_sip = m_udp_ip_source_ip;
         prev_dip = m_udp_ip_dest_ip;

         if (m_udp_payload_axis_tvalid) begin
            check("pay_busy", 32'(busy), 32'd1);
            check("pay_tuser", 32'(m_udp_payload_axis_tuser), 32'd0);
            if (prev_tv) begin
               check("pay_data_stable", 32'(m_udp_payload_axis_tdata), 32'(prev_td));
               check("pay_last_stable", 32'(m_udp_payload_axis_tlast), 32'(prev_tl));
            end
            if (m_udp_payload_axis_tready) begin
               check("pay_expected", 32'(exp_pay.size() > 0), 32'd1);
               if (exp_pay.size() > 0) begin
                  pb_t p;
                  p = exp_pay.pop_front();
                  check("pay_data", 32'(m_udp_payload_axis_tdata), 32'(p.d));
                  check("pay_last", 32'(m_udp_payload_axis_tlast), 32'(p.l));
               end
               pay_popped++;
            end
         end
         prev_tv = m_udp_payload_axis_tvalid && !m_udp_payload_axis_tready;
         prev_td = m_udp_payload_axis_tdata;
         prev_tl = m_udp_payload_axis_tlast;
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_s_tready", 32'(s_axis_tready), 32'd1);
      check("rst_hdr_valid", 32'(m_udp_hdr_valid), 32'd0);
      check("rst_pay_valid", 32'(m_udp_payload_axis_tvalid), 32'd0);
      check("rst_pay_last", 32'(m_udp_payload_axis_tlast), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_length", 32'(m_udp_length), 32'd8);
      check("rst_src_ip", m_udp_ip_source_ip, 32'd0);
      check("rst_dst_ip", m_udp_ip_dest_ip, 32'd0);

      // Short datagram closed by tlast.
      for (int i = 0; i < 4; i++)
         send_byte(8'(8'h11 + i), (i == 3));
      wait_idle();

      // Full buffer with no tlast.
      for (int i = 0; i < MAX; i++)
         send_byte(8'($urandom), 1'b0);
      wait_idle();

      // Idle timeout with a partial buffer, then a long idle stretch with an empty buffer.
      local_ip = 32'h0A00_0001;
      for (int i = 0; i < 3; i++)
         send_byte(8'(8'hA0 + i), 1'b0);
      idle_cycles(TO + 200);
      wait_idle();

      // Header held off; IP inputs wander while the header waits.
      hdr_hold = 50;
      for (int i = 0; i < 6; i++)
         send_byte(8'($urandom), (i == 5));
      for (int i = 0; i < 60; i++) begin
         remote_ip = $urandom;
         local_ip  = $urandom;
         idle_cycles(1);
      end
      hdr_hold = 0;
      wait_idle();

      // Random sizes with random backpressure on both output channels.
      hdr_pct = 70;
      pay_pct = 50;
      for (int dg = 0; dg < 10; dg++) begin
         n = (dg == 0) ? MAX : (dg == 1) ? 1 : int'($urandom_range(1, MAX));
         remote_ip = $urandom;
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(7) == 0)
               idle_cycles(int'($urandom_range(1, 3)));
            send_byte(8'($urandom), (i == n - 1));
         end
      end
      wait_idle();

      // Reset pulse in the middle of a payload.
      hdr_pct = 100;
      pay_pct = 100;
      pay_popped = 0;
      for (int i = 0; i < 500; i++)
         send_byte(8'($urandom), (i == 499));
      n = 0;
      while (pay_popped < 200 && n < 5000) begin
         idle_cycles(1);
         n++;
      end
      check("mid_send_bound", 32'(pay_popped >= 200), 32'd1);
      pay_force_low = 1'b1;
      idle_cycles(2);
      rst = 1'b1;
      exp_hdr.delete();
      exp_pay.delete();
      pend.delete();
      idle = 0;
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_pay_valid", 32'(m_udp_payload_axis_tvalid), 32'd0);
      check("post_rst_hdr_valid", 32'(m_udp_hdr_valid), 32'd0);
      check("post_rst_s_tready", 32'(s_axis_tready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_length", 32'(m_udp_length), 32'd8);
      pay_force_low = 1'b0;
      for (int i = 0; i < 5; i++)
         send_byte(8'(8'h50 + i), (i == 4));
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
